// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the bus transfer controller.
package bus_ctrl_pkg;

  localparam int unsigned BUS_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    LATCH   = 3'd2,
    RELEASE = 3'd3,
    INC     = 3'd4,
    ERR     = 3'd5
  } state_t;

  // A register index is legal when it addresses an existing register.
  function automatic logic idx_legal(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/bus_transfer_controller_if.sv
// Command handshake and register-bank strobes of the bus transfer controller.
interface bus_transfer_controller_if #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = 3
) ();

  logic                req_valid;
  logic                req_ready;
  logic [SEL_W-1:0]    req_src;
  logic [SEL_W-1:0]    req_dst;
  logic                req_inc;
  logic [NUM_REGS-1:0] enable;
  logic [NUM_REGS-1:0] latch;
  logic [NUM_REGS-1:0] increment;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output req_valid, req_src, req_dst, req_inc,
    input  req_ready, enable, latch, increment, busy, done, err
  );

  modport slave (
    input  req_valid, req_src, req_dst, req_inc,
    output req_ready, enable, latch, increment, busy, done, err
  );

endinterface

// File: rtl/bus_transfer_controller_onehot_decoder.sv
// Gated index-to-one-hot decoder; out-of-range indices decode to all zeros.
module onehot_decoder #(
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic [SEL_W-1:0]    idx,
  input  logic                gate,
  output logic [NUM_REGS-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (gate && (idx == SEL_W'(i))) onehot_c[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_transfer_controller.sv
// Sequences one register-to-register bus move at a time, with a guard cycle
// between bus drivers and an optional post-increment of the destination.
module bus_transfer_controller
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input logic                      clk,
  input logic                      reset,
  bus_transfer_controller_if.slave bus
);

  state_t              state;
  logic [SEL_W-1:0]    src_q;
  logic [SEL_W-1:0]    dst_q;
  logic                inc_q;

  logic                accept_c;
  logic                legal_c;
  logic                same_c;
  logic                en_gate_c;
  logic                lt_gate_c;
  logic                inc_gate_c;
  logic [SEL_W-1:0]    en_idx_c;
  logic [SEL_W-1:0]    inc_idx_c;
  logic [NUM_REGS-1:0] en_nxt_c;
  logic [NUM_REGS-1:0] lt_nxt_c;
  logic [NUM_REGS-1:0] inc_nxt_c;

  // Strobe requests for the next cycle; in IDLE they come straight from the command.
  always_comb begin
    accept_c   = bus.req_valid && (state == IDLE);
    same_c     = (bus.req_src == bus.req_dst);
    legal_c    = idx_legal(32'(bus.req_src), NUM_REGS) &&
                 idx_legal(32'(bus.req_dst), NUM_REGS) &&
                 (!same_c || bus.req_inc);
    en_idx_c   = (state == IDLE) ? bus.req_src : src_q;
    inc_idx_c  = (state == IDLE) ? bus.req_dst : dst_q;
    en_gate_c  = (accept_c && legal_c && !same_c) || (state == DRIVE);
    lt_gate_c  = (state == DRIVE);
    inc_gate_c = (accept_c && legal_c && same_c) || ((state == RELEASE) && inc_q);
  end

  onehot_decoder #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dec_enable (
    .idx      (en_idx_c),
    .gate     (en_gate_c),
    .onehot_c (en_nxt_c)
  );

  onehot_decoder #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dec_latch (
    .idx      (dst_q),
    .gate     (lt_gate_c),
    .onehot_c (lt_nxt_c)
  );

  onehot_decoder #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dec_increment (
    .idx      (inc_idx_c),
    .gate     (inc_gate_c),
    .onehot_c (inc_nxt_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      inc_q         <= 1'b0;
      bus.enable    <= '0;
      bus.latch     <= '0;
      bus.increment <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.req_ready <= 1'b1;
    end else begin
      bus.enable    <= en_nxt_c;
      bus.latch     <= lt_nxt_c;
      bus.increment <= inc_nxt_c;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            src_q         <= bus.req_src;
            dst_q         <= bus.req_dst;
            inc_q         <= bus.req_inc;
            bus.busy      <= 1'b1;
            bus.req_ready <= 1'b0;
            if (!legal_c)    state <= ERR;
            else if (same_c) state <= INC;
            else             state <= DRIVE;
          end
        end
        DRIVE:   state <= LATCH;
        LATCH:   state <= RELEASE;
        RELEASE: begin
          if (inc_q) begin
            state <= INC;
          end else begin
            state         <= IDLE;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        INC: begin
          state         <= IDLE;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        ERR: begin
          state         <= IDLE;
          bus.done      <= 1'b1;
          bus.err       <= 1'b1;
          bus.busy      <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
